// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer: FSM state encodings and default widths.
// No logic; imported by the top and the fetch queue.
package if_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_KILL = 2'd2
  } if_state_t;

  localparam int IF_IW_DEFAULT    = 32;
  localparam int IF_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// Sync FIFO of {pc,instr}; head is read from registered storage, so a push at edge N shows after N.
// Full/empty come from the registered count only; push when full and pop when empty are ignored.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetches the word at pc_addr over req/ack and queues {pc,instr} for decode; a push lands on if_* one cycle later.
// PC is held (stall_ctr=1) until the fetch is pushed; full queue gates the request off; flush empties the queue.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int instruction_width = IF_IW_DEFAULT,
  parameter int fifo_depth        = IF_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [instruction_width-1:0] pc_addr,
  input  logic                         flush,
  input  logic                         id_stall,
  output logic                         stall_ctr,
  output logic                         imem_req,
  output logic [instruction_width-1:0] imem_addr,
  input  logic                         imem_ack,
  input  logic [instruction_width-1:0] imem_rdata,
  output logic                         if_valid,
  output logic [instruction_width-1:0] if_instr,
  output logic [instruction_width-1:0] if_pc
);

  localparam int IW = instruction_width;

  if_state_t       state;
  logic [IW-1:0]   kill_addr;
  logic            req_int;
  logic [IW-1:0]   addr_int;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [2*IW-1:0] head;

  always_comb begin
    req_int  = 1'b0;
    addr_int = pc_addr;
    case (state)
      IF_IDLE: req_int = ~fifo_full & ~flush;
      IF_WAIT: req_int = 1'b1;
      // Old request must complete on its original address; its data is dropped.
      IF_KILL: begin
        req_int  = 1'b1;
        addr_int = kill_addr;
      end
      default: req_int = 1'b0;
    endcase
  end

  assign push      = ~rst & req_int & imem_ack & ~flush & (state != IF_KILL);
  assign pop       = if_valid & ~id_stall & ~flush;
  assign imem_req  = req_int & ~rst;
  assign imem_addr = addr_int;
  assign stall_ctr = rst | ~(flush | push);
  assign if_valid  = ~fifo_empty & ~rst;
  assign if_pc     = rst ? '0 : head[2*IW-1:IW];
  assign if_instr  = rst ? '0 : head[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IF_IDLE;
      kill_addr <= '0;
    end else begin
      case (state)
        IF_IDLE: if (req_int & ~imem_ack) state <= IF_WAIT;
        IF_WAIT: begin
          if (imem_ack) begin
            state <= IF_IDLE;
          end else if (flush) begin
            kill_addr <= pc_addr;
            state     <= IF_KILL;
          end
        end
        IF_KILL: if (imem_ack) state <= IF_IDLE;
        default: state <= IF_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH(2*IW),
    .DEPTH(fifo_depth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({pc_addr, imem_rdata}),
    .pop      (pop),
    .clear    (flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

endmodule
